pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port Clock  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ID_Rs, ID_Rt  input  5 each  source register fields of the instruction in ID.
REQ-004 SHALL have port ID_UsesRs, ID_UsesRt  input  1 each  the ID instruction reads Rs/Rt.
REQ-005 SHALL have port EX_MemRead  input  1  the instruction in EX is a load.
REQ-006 SHALL have port EX_Rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port EX_BranchTaken  input  1  branch resolved taken in EX.
REQ-008 SHALL have port ID_Jump  input  1  jump decoded in ID.
REQ-009 SHALL have port MemStall  input  1  data memory not ready; pipeline must freeze.
REQ-010 SHALL have ports PC_WE, IFID_WE, IDEX_WE, EXMEM_WE  output  1 each  stage write enables.
REQ-011 SHALL have ports IFID_Flush, IDEX_Flush  output  1 each  ORed into the stage register's synchronous Reset, which overrides its WriteEnable.
REQ-012 SHALL have port Timeout  output  1  sticky memory-wait timeout flag.
REQ-013 SHALL have ports StallCycles, FlushCount  output  16 each  saturating performance counters.
REQ-014 SHALL have port State  output  2  current FSM state, for debug.

Function
REQ-015 Enables and flushes SHALL be combinational in current state and inputs (same-cycle effect); counters, Timeout and state SHALL be registered.
REQ-016 FSM states SHALL be RUN=0, MEM_WAIT=1, TIMEOUT=2; encoding 3 is illegal and SHALL go to RUN.
REQ-017 Default in RUN with no event: all WE=1, all Flush=0.
REQ-018 Priority SHALL be MemStall > EX_BranchTaken > load-use > ID_Jump.
REQ-019 Load-use SHALL be EX_MemRead && EX_Rd!=0 && ((ID_UsesRs && ID_Rs==EX_Rd) || (ID_UsesRt && ID_Rt==EX_Rd)).
REQ-020 Load-use SHALL drive PC_WE=0, IFID_WE=0, IDEX_Flush=1 for exactly that cycle; one bubble.
REQ-021 EX_BranchTaken SHALL drive IFID_Flush=1 and IDEX_Flush=1 with PC_WE=1, suppressing any same-cycle load-use or jump response.
REQ-022 ID_Jump without a higher-priority event SHALL drive IFID_Flush=1 only.
REQ-023 ID_Jump together with load-use SHALL stall; the jump flush occurs on the later cycle when the hazard clears.
REQ-024 MemStall in RUN or MEM_WAIT SHALL drive all WE=0 and all Flush=0, ignoring every other input.
REQ-025 RUN SHALL go to MEM_WAIT when MemStall=1; MEM_WAIT SHALL return to RUN on the first cycle MemStall=0, with normal RUN behaviour in that cycle.
REQ-026 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-027 When the wait counter reaches 255 with MemStall still 1, the FSM SHALL go to TIMEOUT and set Timeout=1.
REQ-028 TIMEOUT SHALL hold all WE=0 and Flush=0 regardless of inputs; only Reset exits.
REQ-029 StallCycles SHALL increment on every cycle in which PC_WE=0.
REQ-030 FlushCount SHALL increment on every cycle in which any Flush=1.
REQ-031 Both counters SHALL saturate at 16'hFFFF.

Reset
REQ-032 Reset SHALL set State=RUN, wait counter=0, Timeout=0, StallCycles=0 and FlushCount=0.
REQ-033 While Reset=1, outputs SHALL be all WE=1 and Flush=0.
REQ-034 Reset mid-MEM_WAIT or mid-TIMEOUT SHALL take effect on the next edge.

Structure
REQ-035 A shared package SHALL hold the state encoding, WAIT_LIMIT=255 and CNT_W=16.
REQ-036 A sub-module sat_counter, with increment enable and synchronous clear, SHALL be instantiated for StallCycles and FlushCount.

Verification
REQ-037 EX_MemRead=1, EX_Rd=5, ID_Rs=5, ID_UsesRs=1 -> one cycle of PC_WE=0, IFID_WE=0, IDEX_Flush=1; StallCycles=1.
REQ-038 The REQ-037 stimulus plus EX_BranchTaken=1 in the same cycle -> IFID_Flush=IDEX_Flush=1, PC_WE=1; StallCycles unchanged; FlushCount+1.
REQ-039 EX_Rd=0 with a matching ID_Rs=0 load -> no stall.
REQ-040 MemStall high 10 cycles -> all WE=0 for 10 cycles, State=1; RUN on the 11th cycle; StallCycles=10.
REQ-041 MemStall held 300 cycles -> Timeout=1 and State=2 after 256 MEM_WAIT cycles; the state persists after MemStall drops until Reset.
REQ-042 Force 70000 stall cycles -> StallCycles=16'hFFFF and stays there.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and limits for the pipeline hazard controller.
// Holds FSM encoding, wait limit, counter width and the load-use test.
package pipeline_hazard_ctrl_pkg;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
  } we_t;

  typedef struct packed {
    logic ifid;
    logic idex;
  } flush_t;

  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs,
    input logic       uses_rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return mem_read && (ex_rd != 5'd0) &&
           ((uses_rs && (rs == ex_rd)) ||
            (uses_rt && (rt == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
// Ports: Clock, Clear (sync), Inc (enable), Count (sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Clear,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clock) begin
    if (Clear) begin
      Count <= '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline with memory-wait timeout.
// In: ID/EX hazard info, branch/jump, MemStall. Out: WEs, flushes, perf.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_BranchTaken,
  input  logic             ID_Jump,
  input  logic             MemStall,
  output logic             PC_WE,
  output logic             IFID_WE,
  output logic             IDEX_WE,
  output logic             EXMEM_WE,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Timeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       State
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, set_to;
  logic              hazard;
  we_t               run_we, we;
  flush_t            run_fl, fl;

  assign hazard = load_use(EX_MemRead, EX_Rd, ID_Rs,
                           ID_UsesRs, ID_Rt, ID_UsesRt);

  // Free-running response, used whenever the pipeline may advance.
  always_comb begin
    run_we = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1};
    run_fl = '0;
    if (EX_BranchTaken) begin
      run_fl = '{ifid: 1'b1, idex: 1'b1};
    end else if (hazard) begin
      // Jump waits: the flush follows once the bubble is inserted.
      run_we.pc   = 1'b0;
      run_we.ifid = 1'b0;
      run_fl.idex = 1'b1;
    end else if (ID_Jump) begin
      run_fl.ifid = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    set_to  = 1'b0;
    we      = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1};
    fl      = '0;
    if (!Reset) begin
      unique case (state_q)
        RUN: begin
          if (MemStall) begin
            we      = '0;
            state_d = MEM_WAIT;
            wait_d  = '0;
          end else begin
            we = run_we;
            fl = run_fl;
          end
        end
        MEM_WAIT: begin
          if (MemStall) begin
            we = '0;
            if (wait_q == WAIT_LIMIT) begin
              state_d = TIMEOUT;
              set_to  = 1'b1;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end else begin
            we      = run_we;
            fl      = run_fl;
            state_d = RUN;
          end
        end
        TIMEOUT: begin
          we = '0;
        end
        default: begin
          we      = run_we;
          fl      = run_fl;
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_to) timeout_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clock (Clock),
    .Clear (Reset),
    .Inc   (~we.pc),
    .Count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clock (Clock),
    .Clear (Reset),
    .Inc   (fl.ifid | fl.idex),
    .Count (FlushCount)
  );

  assign PC_WE      = we.pc;
  assign IFID_WE    = we.ifid;
  assign IDEX_WE    = we.idex;
  assign EXMEM_WE   = we.exmem;
  assign IFID_Flush = fl.ifid;
  assign IDEX_Flush = fl.idex;
  assign Timeout    = timeout_q;
  assign State      = state_q;

endmodule
